// File: rtl/mem_responder_if.sv
// Request/response channel between the pipeline memory stage and mem_responder.
// master drives requests and accepts responses; slave is the responder side.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [63:0] req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder over a 64-bit word array with bit-masked writes.
// Define MEM_RESP_ALIGN_CHK_EN to reject addresses that are not 8-byte aligned.
module mem_responder #(
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2
) (
  input logic            clk_i,
  input logic            rst_ni,
  mem_responder_if.slave bus
);

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [63:0] DEPTH64  = 64'(DEPTH);
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] wmask_q, wmask_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        out_en_q;

  logic [63:0] mem [DEPTH];

  logic                  accept;
  logic [63:0]           acc_addr, acc_wdata, acc_wmask, acc_word;
  logic                  acc_wen, acc_rej, enter_resp, do_write;
  logic [DEPTH_LOG2-1:0] acc_idx;

  assign accept = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      out_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = bus.req_addr;
          wen_d   = bus.req_wen;
          wdata_d = bus.req_wdata;
          wmask_d = bus.req_wmask;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY==1 the access happens on the accept edge, so use the live request.
  always_comb begin
    acc_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
    acc_wen   = (state_q == IDLE) ? bus.req_wen   : wen_q;
    acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
    acc_wmask = (state_q == IDLE) ? bus.req_wmask : wmask_q;
    acc_word  = (acc_addr - BASE_ADDR) >> 3;
    acc_idx   = acc_word[DEPTH_LOG2-1:0];
    acc_rej   = (acc_addr < BASE_ADDR) || (acc_word >= DEPTH64);
`ifdef MEM_RESP_ALIGN_CHK_EN
    acc_rej   = acc_rej || (acc_addr[2:0] != 3'b000);
`endif
    enter_resp = (state_d == RESP) && (state_q != RESP);
    do_write   = enter_resp && !acc_rej && acc_wen;
    rdata_d    = rdata_q;
    err_d      = err_q;
    if (enter_resp) begin
      err_d   = acc_rej;
      rdata_d = acc_rej ? 64'd0 : mem[acc_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      mem[acc_idx] <= (mem[acc_idx] & ~acc_wmask) | (acc_wdata & acc_wmask);
    end
  end

  // out_en_q keeps req_ready low until the first edge after reset release.
  always_comb begin
    bus.req_ready  = out_en_q && (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed checks of mem_responder against an associative-array memory model.
// Honours MEM_RESP_ALIGN_CHK_EN the same way the design does.
module tb_mem_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          DL2  = 12;
  localparam int          LAT  = 2;
  localparam logic [63:0] NWORDS = 64'(1) << DL2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [63:0] mdl [logic [63:0]];

  mem_responder_if bus ();

  mem_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_LOG2 (DL2),
    .LATENCY    (LAT)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the request already accepted (or in flight).
  task automatic finish_resp(output logic [63:0] rd, output logic er, output int lat);
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("resp_timeout", 64'(lat < 40), 64'd1);
    rd = bus.resp_rdata;
    er = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("idle_after_hs", {62'd0, bus.req_ready, bus.resp_valid}, 64'd2);
  endtask

  task automatic txn(input logic [63:0] a, input logic w, input logic [63:0] d,
                     input logic [63:0] m, output logic [63:0] rd, output logic er,
                     output int lat);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_timeout", 64'(n < 40), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_wen   = w;
    bus.req_wdata = d;
    bus.req_wmask = m;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("ready_drop", 64'(bus.req_ready), 64'd0);
    finish_resp(rd, er, lat);
  endtask

  task automatic do_check(input string tag, input logic [63:0] a, input logic w,
                          input logic [63:0] d, input logic [63:0] m,
                          output logic [63:0] rd);
    logic [63:0] word;
    logic        exp_err;
    logic        er;
    int          lat;
    word    = (a - BASE) >> 3;
    exp_err = (a < BASE) || (word >= NWORDS);
`ifdef MEM_RESP_ALIGN_CHK_EN
    exp_err = exp_err || (a[2:0] != 3'b000);
`endif
    txn(a, w, d, m, rd, er, lat);
    check({tag, "_err"}, 64'(er), 64'(exp_err));
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    if (exp_err) check({tag, "_rd0"}, rd, 64'd0);
    else if (mdl.exists(word)) check({tag, "_rd"}, rd, mdl[word]);
    if (!exp_err && w) begin
      if (mdl.exists(word)) mdl[word] = (mdl[word] & ~m) | (d & m);
      else if (m == '1)     mdl[word] = d;
    end
  endtask

  initial begin
    logic [63:0] rd, rd0, dat, msk, addr;
    logic        er;
    int          lat, idx, kind;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wen    = 1'b0;
    bus.req_wdata  = '0;
    bus.req_wmask  = '0;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_rdata", bus.resp_rdata, 64'd0);
    check("rst_err", 64'(bus.resp_err), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready_low", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    check("rel_ready_high", 64'(bus.req_ready), 64'd1);

    // Give the words the bench touches known contents.
    for (int i = 0; i < 16; i++)
      do_check("init", BASE + 64'(i) * 8, 1'b1, {$urandom, $urandom}, '1, rd);
    do_check("init_top", BASE + (NWORDS - 1) * 8, 1'b1, {$urandom, $urandom}, '1, rd);

    do_check("t1_wr", 64'h8000_0008, 1'b1, 64'hDEADBEEF_CAFEF00D, '1, rd);
    do_check("t1_rd", 64'h8000_0008, 1'b0, '0, '0, rd);
    check("t1_val", rd, 64'hDEADBEEF_CAFEF00D);
    do_check("t2_wr", 64'h8000_0008, 1'b1, 64'h11111111_22222222, 64'h0000_0000_FFFF_FFFF, rd);
    check("t2_old", rd, 64'hDEADBEEF_CAFEF00D);
    do_check("t2_rd", 64'h8000_0008, 1'b0, '0, '0, rd);
    check("t2_val", rd, 64'hDEADBEEF_22222222);

    // Response backpressure with a second request waiting.
    bus.req_valid = 1'b1;
    bus.req_addr  = BASE;
    bus.req_wen   = 1'b0;
    @(negedge clk);
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("t3_lat", 64'(lat), 64'(LAT));
    rd0 = bus.resp_rdata;
    check("t3_rd", rd0, mdl[64'd0]);
    bus.req_addr = BASE + 8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_vld", 64'(bus.resp_valid), 64'd1);
      check("t3_hold_rd", bus.resp_rdata, rd0);
      check("t3_hold_rdy", 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("t3_idle", {62'd0, bus.req_ready, bus.resp_valid}, 64'd2);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("t3_second_acc", 64'(bus.req_ready), 64'd0);
    finish_resp(rd, er, lat);
    check("t3_second_rd", rd, mdl[64'd1]);
    check("t3_second_err", 64'(er), 64'd0);

    do_check("t4_lo_rd", 64'h7FFF_FFF8, 1'b0, '0, '0, rd);
    do_check("t4_lo_wr", 64'h7FFF_FFF8, 1'b1, '1, '1, rd);
    do_check("t4_hi_rd", BASE + (64'd8 << DL2), 1'b0, '0, '0, rd);
    do_check("t4_hi_wr", BASE + (64'd8 << DL2), 1'b1, '1, '1, rd);
    do_check("t4_chk0", BASE, 1'b0, '0, '0, rd);
    do_check("t4_chktop", BASE + (NWORDS - 1) * 8, 1'b0, '0, '0, rd);

    // Reset while the write sits in BUSY must leave the word untouched.
    bus.req_valid = 1'b1;
    bus.req_addr  = 64'h8000_0010;
    bus.req_wen   = 1'b1;
    bus.req_wdata = ~mdl[64'd2];
    bus.req_wmask = '1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_vld", 64'(bus.resp_valid), 64'd0);
    check("t5_rdy", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_check("t5_rd", 64'h8000_0010, 1'b0, '0, '0, rd);

    do_check("t6_mis", 64'h8000_0009, 1'b0, '0, '0, rd);

    for (int it = 0; it < 60; it++) begin
      idx  = int'($urandom_range(0, 15));
      kind = int'($urandom_range(0, 9));
      addr = BASE + 64'(idx) * 8;
      if (kind == 0) addr = BASE + (NWORDS + 64'($urandom_range(0, 99))) * 8;
      else if (kind == 1) addr = addr + 64'($urandom_range(1, 7));
      case ($urandom_range(0, 3))
        0:       msk = '1;
        1:       msk = '0;
        default: msk = {$urandom, $urandom};
      endcase
      dat = {$urandom, $urandom};
      do_check("rnd", addr, 1'($urandom_range(0, 1)), dat, msk, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
